hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed single-stage hazard detection of the 3-stage core. It tracks in-flight register writers across a configurable number of post-decode stages and resolves forwarding source per operand. It raises load-use stalls for configurable load latency and generates multi-cycle flush windows on branch redirect and trap/mret. It sits beside Decode, fed by decoded instruction fields, and drives the forward selects, stall and flush for the datapath.

Parameters:
NUM_REGS, 32, architectural register count; address width RA = $clog2(NUM_REGS); register 0 never hazards
WB_STAGES, 2, stages between decode and writeback (inclusive of writeback); 1..7
LOAD_LAT, 1, extra cycles before load data is forwardable; 0..WB_STAGES-1
FLUSH_DEPTH, 1, cycles flush stays high after a branch redirect; 1..4
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
issue_valid  in  1  decode holds a valid instruction
rs1, rs2  in  RA  source register addresses
rs1_used, rs2_used  in  1  operand actually reads the register file
rd  in  RA  destination register
rd_wr  in  1  instruction writes rd
is_load  in  1  instruction is a load
br_redirect  in  1  branch/jump taken this cycle (PC_sel)
trap_redirect  in  1  interrupt entry or mret (epc_taken)
fwd_a, fwd_b  out  FW = $clog2(WB_STAGES+1)  0 = register file, k = stage k result
stall  out  1  hold fetch/decode, inject bubble
flush  out  1  kill fetch/decode contents
issue_fire  out  1  issue_valid & ~stall & ~flush
stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

Behaviour:
- Tracking table: WB_STAGES entries {valid, rd, is_load, age}. Entry k is stage k. Every cycle all entries shift k -> k+1. Entry WB_STAGES retires.
- Stage 1 is loaded with {issue_fire & rd_wr & rd!=0, rd, is_load}; otherwise a bubble (valid=0).
- Ready rule: entry k forwardable iff valid & (~is_load | k >= 1+LOAD_LAT).
- Operand match: rsX_used & rsX!=0 & entry valid & entry.rd==rsX. The youngest (smallest k) match wins.
- fwd_X = k of the youngest match when that entry is ready; 0 if no match. Combinational.
- stall = issue_valid & (youngest match for either operand not ready). Combinational. Stall for a load at stage k lasts exactly 1+LOAD_LAT-k cycles; no further stall once ready.
- Branch redirect: on br_redirect, flush=1 that cycle. A down-counter loads FLUSH_DEPTH-1 and flush stays high while it is nonzero. The stage-1 entry captured that cycle is forced invalid.
- Trap redirect: flush=1 and all table entries except stage WB_STAGES are invalidated at the edge. The counter loads FLUSH_DEPTH-1.
- Simultaneous br_redirect and trap_redirect: trap behaviour applies.
- Redirect while the counter is nonzero: the counter reloads (the window restarts).
- flush has priority over stall. When both conditions hold, stall=0, flush=1, and issue_fire=0.
- stall_cnt increments on every stall cycle; flush_cnt increments on every flush cycle. Both saturate at all-ones.
- Reset (rst=0 at the edge): all entries invalid, flush counter 0, perf counters 0.
- Outputs while rst=0: flush=1, stall=0, fwd_a=fwd_b=0, issue_fire=0. This matches the datapath's flush-on-reset convention.
- Reset mid-stall or mid-flush-window aborts it. The first cycle after release has no hazards.

Test Plan:
- Defaults. ADD x5 issued, next instr rs1=x5 -> fwd_a=1, stall=0. One cycle later (x5 at stage 2), another reader of x5 -> fwd_a=2. A third reader -> fwd_a=0.
- LOAD_LAT=1. LW x7 then ADD rs2=x7 -> stall=1 for exactly 1 cycle, then fwd_b=2. stall_cnt=1.
- Two writers to x3 back-to-back, then reader -> fwd_a=1 (the youngest). Reader with rs1=x0 matching an x0 writer -> fwd_a=0, no stall.
- FLUSH_DEPTH=3. Pulse br_redirect -> flush high 3 cycles, issue_fire=0, flush_cnt=3. A second redirect in cycle 2 -> window extends to cycle 4.
- trap_redirect with stage-1 LW x9 pending and reader of x9 waiting -> table cleared, stall drops next cycle, fwd_a=0.
- Hold rst=0 during an active load-use stall -> flush=1, stall=0, counters 0. After release, a reader of the old rd -> fwd=0, no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight writers per post-decode stage, picks forwarding
// sources, raises load-use stalls and holds flush for a window after branch or trap redirects.
module hazard_scoreboard #(
    parameter  int unsigned NUM_REGS    = 32,
    parameter  int unsigned WB_STAGES   = 2,
    parameter  int unsigned LOAD_LAT    = 1,
    parameter  int unsigned FLUSH_DEPTH = 1,
    parameter  int unsigned CNT_W       = 32,
    localparam int unsigned RA          = $clog2(NUM_REGS),
    localparam int unsigned FW          = $clog2(WB_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [RA-1:0]    rs1,
    input  logic [RA-1:0]    rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [RA-1:0]    rd,
    input  logic             rd_wr,
    input  logic             is_load,
    input  logic             br_redirect,
    input  logic             trap_redirect,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic             stall,
    output logic             flush,
    output logic             issue_fire,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned     FC_W         = 2;
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_DEPTH - 1);

    // Index i of the table holds pipeline stage i+1.
    logic [WB_STAGES-1:0] vld_q, vld_d;
    logic [WB_STAGES-1:0] ld_q,  ld_d;
    logic [RA-1:0]        rd_q [WB_STAGES];
    logic [RA-1:0]        rd_d [WB_STAGES];
    logic [FC_W-1:0]      fcnt_q, fcnt_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic          hit_a, rdy_a, hit_b, rdy_b;
    logic [FW-1:0] sel_a, sel_b;
    logic          redirect, flush_win;

    assign redirect  = br_redirect | trap_redirect;
    assign flush_win = redirect | (fcnt_q != '0);

    // Scanning from stage 1 upward and latching the first hit gives youngest-match priority.
    always_comb begin
        hit_a = 1'b0;
        rdy_a = 1'b0;
        sel_a = '0;
        hit_b = 1'b0;
        rdy_b = 1'b0;
        sel_b = '0;
        for (int unsigned i = 0; i < WB_STAGES; i++) begin
            if (!hit_a && rs1_used && (rs1 != '0) && vld_q[i] && (rd_q[i] == rs1)) begin
                hit_a = 1'b1;
                rdy_a = !ld_q[i] || (i >= LOAD_LAT);
                sel_a = FW'(i + 1);
            end
            if (!hit_b && rs2_used && (rs2 != '0) && vld_q[i] && (rd_q[i] == rs2)) begin
                hit_b = 1'b1;
                rdy_b = !ld_q[i] || (i >= LOAD_LAT);
                sel_b = FW'(i + 1);
            end
        end
    end

    always_comb begin
        flush      = 1'b1;
        stall      = 1'b0;
        fwd_a      = '0;
        fwd_b      = '0;
        issue_fire = 1'b0;
        if (rst) begin
            flush      = flush_win;
            stall      = !flush_win && issue_valid && ((hit_a && !rdy_a) || (hit_b && !rdy_b));
            fwd_a      = (hit_a && rdy_a) ? sel_a : '0;
            fwd_b      = (hit_b && rdy_b) ? sel_b : '0;
            issue_fire = issue_valid && !stall && !flush_win;
        end
    end

    always_comb begin
        vld_d[0] = issue_fire && rd_wr && (rd != '0);
        ld_d[0]  = is_load;
        rd_d[0]  = rd;
        for (int unsigned i = 1; i < WB_STAGES; i++) begin
            vld_d[i] = vld_q[i-1];
            ld_d[i]  = ld_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
        // The oldest entry retires this edge regardless, so a trap empties the whole table.
        if (trap_redirect) begin
            vld_d = '0;
        end

        fcnt_d = fcnt_q;
        if (redirect) begin
            fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - FC_W'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q       <= '0;
            ld_q        <= '0;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int unsigned i = 0; i < WB_STAGES; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            ld_q        <= ld_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int unsigned i = 0; i < WB_STAGES; i++) begin
                rd_q[i] <= rd_d[i];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed plus randomized bench for hazard_scoreboard, checked against a timestamp-based
// model of in-flight writers (stage = cycles since issue) and redirect windows.
module tb_hazard_scoreboard;

    localparam int unsigned WB   = 2;
    localparam int unsigned LL   = 1;
    localparam int unsigned FD   = 3;
    localparam int unsigned CW   = 4;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          issue_valid;
    logic [4:0]    rs1, rs2, rd;
    logic          rs1_used, rs2_used, rd_wr, is_load, br_redirect, trap_redirect;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall, flush, issue_fire;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_scoreboard #(
        .NUM_REGS   (32),
        .WB_STAGES  (WB),
        .LOAD_LAT   (LL),
        .FLUSH_DEPTH(FD),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rd           (rd),
        .rd_wr        (rd_wr),
        .is_load      (is_load),
        .br_redirect  (br_redirect),
        .trap_redirect(trap_redirect),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall),
        .flush        (flush),
        .issue_fire   (issue_fire),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int rd;
        bit ld;
        int t;
    } writer_t;

    writer_t wq[$];
    int cyc        = 0;
    int last_redir = -100;
    int m_scnt     = 0;
    int m_fcnt     = 0;
    int n_run      = 0;
    int n_fail     = 0;

    int e_fwd_a, e_fwd_b;
    bit e_stall, e_flush, e_fire;
    bit c_rst, c_iv, c_wr, c_ld, c_br, c_tr;
    int c_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Youngest writer of rs still inside the pipeline; ready once loads have aged past the latency.
    task automatic lookup(input int rs, input bit used, output int fwd, output bit not_rdy);
        int best_t;
        int age;
        best_t  = -1000;
        fwd     = 0;
        not_rdy = 1'b0;
        if (used && rs != 0) begin
            foreach (wq[j]) begin
                age = cyc - wq[j].t;
                if (wq[j].rd == rs && age >= 1 && age <= int'(WB) && wq[j].t > best_t) begin
                    best_t = wq[j].t;
                    if (!wq[j].ld || age >= 1 + int'(LL)) begin
                        fwd     = age;
                        not_rdy = 1'b0;
                    end else begin
                        fwd     = 0;
                        not_rdy = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cyc_begin(input bit r, input bit iv, input int a, input bit ua, input int b,
                             input bit ub, input int d, input bit wr, input bit ld,
                             input bit br, input bit tr);
        bit nra, nrb;
        rst           = r;
        issue_valid   = iv;
        rs1           = 5'(a);
        rs2           = 5'(b);
        rs1_used      = ua;
        rs2_used      = ub;
        rd            = 5'(d);
        rd_wr         = wr;
        is_load       = ld;
        br_redirect   = br;
        trap_redirect = tr;
        c_rst = r; c_iv = iv; c_wr = wr; c_ld = ld; c_br = br; c_tr = tr; c_rd = d;
        #1;
        if (!r) begin
            e_fwd_a = 0; e_fwd_b = 0; e_stall = 0; e_flush = 1; e_fire = 0;
        end else begin
            lookup(a, ua, e_fwd_a, nra);
            lookup(b, ub, e_fwd_b, nrb);
            e_flush = br || tr || (cyc - last_redir < int'(FD));
            e_stall = !e_flush && iv && (nra || nrb);
            e_fire  = iv && !e_stall && !e_flush;
        end
        check("fwd_a", 32'(fwd_a), 32'(e_fwd_a));
        check("fwd_b", 32'(fwd_b), 32'(e_fwd_b));
        check("stall", 32'(stall), 32'(e_stall));
        check("flush", 32'(flush), 32'(e_flush));
        check("issue_fire", 32'(issue_fire), 32'(e_fire));
        check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        check("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    endtask

    task automatic cyc_end();
        @(posedge clk);
        if (!c_rst) begin
            wq.delete();
            last_redir = -100;
            m_scnt     = 0;
            m_fcnt     = 0;
        end else begin
            if (c_tr) wq.delete();
            if (e_fire && c_wr && c_rd != 0) wq.push_back('{rd: c_rd, ld: c_ld, t: cyc});
            if (c_br || c_tr) last_redir = cyc;
            if (e_stall && m_scnt < MAXC) m_scnt++;
            if (e_flush && m_fcnt < MAXC) m_fcnt++;
        end
        cyc++;
        while (wq.size() > 0 && cyc - wq[0].t > int'(WB)) void'(wq.pop_front());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc_begin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cyc_end();
        end
    endtask

    initial begin
        rst = 1'b0; issue_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd = '0; rd_wr = 1'b0; is_load = 1'b0; br_redirect = 1'b0; trap_redirect = 1'b0;
        @(negedge clk);

        // Reset held: flush asserted, everything else quiet
        cyc_begin(0, 1, 5, 1, 5, 1, 5, 1, 0, 0, 0);
        check("rst_flush", 32'(flush), 32'd1);
        check("rst_fire", 32'(issue_fire), 32'd0);
        cyc_end();

        // Forwarding from stage 1, stage 2, then retired
        cyc_begin(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0); cyc_end();
        cyc_begin(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("fwd_stage1", 32'(fwd_a), 32'd1);
        cyc_end();
        cyc_begin(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("fwd_stage2", 32'(fwd_a), 32'd2);
        cyc_end();
        cyc_begin(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        check("fwd_retired", 32'(fwd_a), 32'd0);
        cyc_end();

        // Load-use: one stall cycle, then forward from stage 2
        cyc_begin(1, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0); cyc_end();
        cyc_begin(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        check("lu_stall", 32'(stall), 32'd1);
        cyc_end();
        cyc_begin(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        check("lu_nostall", 32'(stall), 32'd0);
        check("lu_fwd_b", 32'(fwd_b), 32'd2);
        cyc_end();
        cyc_begin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        cyc_end();

        // Youngest of two writers wins; x0 never hazards
        cyc_begin(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc_end();
        cyc_begin(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0); cyc_end();
        cyc_begin(1, 1, 3, 1, 0, 0, 0, 1, 1, 0, 0);
        check("youngest_stall", 32'(stall), 32'd1);
        cyc_end();
        idle(2);
        cyc_begin(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc_end();
        cyc_begin(1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0); cyc_end();
        cyc_begin(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        check("youngest_fwd", 32'(fwd_a), 32'd1);
        cyc_end();
        cyc_begin(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0); cyc_end();
        cyc_begin(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        check("x0_fwd", 32'(fwd_a), 32'd0);
        check("x0_stall", 32'(stall), 32'd0);
        cyc_end();

        // Branch redirect window of three cycles, then restart mid-window
        cyc_begin(1, 1, 0, 0, 0, 0, 4, 1, 0, 1, 0);
        check("br_fire", 32'(issue_fire), 32'd0);
        cyc_end();
        for (int i = 1; i < 4; i++) begin
            cyc_begin(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
            check("br_window", 32'(flush), (i < 3) ? 32'd1 : 32'd0);
            if (i == 3) check("br_fwd_killed", 32'(fwd_a), 32'd0);
            cyc_end();
        end
        check("br_flush_cnt", 32'(flush_cnt), 32'd3);
        for (int i = 0; i < 6; i++) begin
            cyc_begin(1, 1, 0, 0, 0, 0, 0, 0, 0, (i == 0 || i == 2), 0);
            check("br_restart", 32'(flush), (i < 5) ? 32'd1 : 32'd0);
            cyc_end();
        end
        check("br2_flush_cnt", 32'(flush_cnt), 32'd8);

        // Trap clears a pending load that a waiting reader depends on
        cyc_begin(1, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0); cyc_end();
        cyc_begin(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        check("trap_flush", 32'(flush), 32'd1);
        check("trap_stall", 32'(stall), 32'd0);
        cyc_end();
        cyc_begin(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        check("trap_cleared_fwd", 32'(fwd_a), 32'd0);
        cyc_end();
        idle(2);

        // Reset during a load-use stall aborts it and forgets the load
        cyc_begin(1, 1, 0, 0, 0, 0, 11, 1, 1, 0, 0); cyc_end();
        cyc_begin(1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_stall", 32'(stall), 32'd1);
        cyc_end();
        cyc_begin(1, 1, 0, 0, 0, 0, 11, 1, 1, 0, 0); cyc_end();
        cyc_begin(0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        check("mid_rst_flush", 32'(flush), 32'd1);
        cyc_end();
        cyc_begin(1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_fwd", 32'(fwd_a), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_scnt", 32'(stall_cnt), 32'd0);
        check("post_rst_fcnt", 32'(flush_cnt), 32'd0);
        cyc_end();

        // Randomized traffic over a small register set; counters saturate along the way
        for (int n = 0; n < 3000; n++) begin
            cyc_begin(($urandom_range(99) != 0), ($urandom_range(3) != 0),
                      int'($urandom_range(7)), $urandom_range(1) == 1,
                      int'($urandom_range(7)), $urandom_range(1) == 1,
                      int'($urandom_range(7)), $urandom_range(3) != 0,
                      $urandom_range(2) == 0, $urandom_range(19) == 0,
                      $urandom_range(39) == 0);
            cyc_end();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
